// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and default latencies for the execute-stage multiply/divide unit.
// The controller imports the same MDOp encodings when decoding MD instructions.
package mult_div_unit_pkg;

   typedef enum logic [2:0] {
      MD_NONE      = 3'd0,
      MD_MULT      = 3'd1,
      MD_MULTU     = 3'd2,
      MD_DIV       = 3'd3,
      MD_DIVU      = 3'd4,
      MD_MTHI      = 3'd5,
      MD_MTLO      = 3'd6,
      MD_MFHI_MFLO = 3'd7
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage MD issue bundle: control and operands in, Busy and HI/LO out.
interface mult_div_unit_if;
   import mult_div_unit_pkg::*;

   logic        Start;
   md_op_e      MDOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        Cancel;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Start, MDOp, A, B, Cancel,
      input  Busy, HI, LO
   );

   modport slave (
      input  Start, MDOp, A, B, Cancel,
      output Busy, HI, LO
   );

endinterface

// File: rtl/mult_div_unit.sv
// Multiply/divide unit owning HI/LO; the result is computed at issue and committed
// after a fixed latency, with Busy covering the whole wait.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no operation in flight; MTHI/MTLO write directly, Start issues
// ST_RUN  | result held in pending regs, down-counter running, Busy=1
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input logic            clk,
   input logic            reset,
   mult_div_unit_if.slave md
);

   md_state_e   state_q, state_d;
   logic [3:0]  count_q, count_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic        pend_valid_q, pend_valid_d;

   logic [63:0] prod_s, prod_u;
   logic        b_zero;
   logic [31:0] div_b_u;
   logic [31:0] q_u, r_u;
   logic [31:0] a_mag, b_mag, div_b_s;
   logic [31:0] q_mag, r_mag;
   logic [31:0] q_s, r_s;

   // Signed divide works on magnitudes so the INT_MIN / -1 case wraps to INT_MIN naturally.
   always_comb begin
      prod_s  = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
      prod_u  = {32'd0, md.A} * {32'd0, md.B};
      b_zero  = (md.B == 32'd0);
      div_b_u = b_zero ? 32'd1 : md.B;
      q_u     = md.A / div_b_u;
      r_u     = md.A % div_b_u;
      a_mag   = md.A[31] ? (32'd0 - md.A) : md.A;
      b_mag   = md.B[31] ? (32'd0 - md.B) : md.B;
      div_b_s = b_zero ? 32'd1 : b_mag;
      q_mag   = a_mag / div_b_s;
      r_mag   = a_mag % div_b_s;
      q_s     = (md.A[31] ^ md.B[31]) ? (32'd0 - q_mag) : q_mag;
      r_s     = md.A[31] ? (32'd0 - r_mag) : r_mag;
   end

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      pend_hi_d    = pend_hi_q;
      pend_lo_d    = pend_lo_q;
      pend_valid_d = pend_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (!md.Cancel) begin
               case (md.MDOp)
                  MD_MULT, MD_MULTU: begin
                     if (md.Start) begin
                        pend_hi_d    = (md.MDOp == MD_MULT) ? prod_s[63:32] : prod_u[63:32];
                        pend_lo_d    = (md.MDOp == MD_MULT) ? prod_s[31:0]  : prod_u[31:0];
                        pend_valid_d = 1'b1;
                        count_d      = 4'(MULT_CYCLES);
                        state_d      = ST_RUN;
                     end
                  end
                  MD_DIV, MD_DIVU: begin
                     if (md.Start) begin
                        pend_hi_d    = (md.MDOp == MD_DIV) ? r_s : r_u;
                        pend_lo_d    = (md.MDOp == MD_DIV) ? q_s : q_u;
                        pend_valid_d = !b_zero;
                        count_d      = 4'(DIV_CYCLES);
                        state_d      = ST_RUN;
                     end
                  end
                  MD_MTHI: hi_d = md.A;
                  MD_MTLO: lo_d = md.A;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            if (md.Cancel) begin
               count_d = 4'd0;
               state_d = ST_IDLE;
            end else if (count_q == 4'd1) begin
               if (pend_valid_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               count_d = 4'd0;
               state_d = ST_IDLE;
            end else begin
               count_d = count_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         count_q      <= 4'd0;
         hi_q         <= 32'd0;
         lo_q         <= 32'd0;
         pend_hi_q    <= 32'd0;
         pend_lo_q    <= 32'd0;
         pend_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         pend_hi_q    <= pend_hi_d;
         pend_lo_q    <= pend_lo_d;
         pend_valid_q <= pend_valid_d;
      end
   end

   assign md.Busy = (state_q == ST_RUN);
   assign md.HI   = hi_q;
   assign md.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: one task per scenario, hand-computed results.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   mult_div_unit_if md_if();

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (md_if.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic start, input logic cancel);
      md_if.MDOp   = op;
      md_if.A      = a;
      md_if.B      = b;
      md_if.Start  = start;
      md_if.Cancel = cancel;
   endtask

   task automatic idle();
      drive(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
      drive(op, a, b, 1'b1, 1'b0);
      step();
      idle();
   endtask

   // Counts cycles with Busy high (bounded) and notes whether HI/LO moved meanwhile.
   task automatic wait_busy(output int n, output bit stable);
      logic [31:0] h0;
      logic [31:0] l0;
      h0 = md_if.HI;
      l0 = md_if.LO;
      n = 0;
      stable = 1'b1;
      while (md_if.Busy === 1'b1 && n < 40) begin
         if (md_if.HI !== h0 || md_if.LO !== l0) stable = 1'b0;
         n++;
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      step();
      step();
      n_cmp++; if (md_if.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", md_if.Busy); end
      n_cmp++; if (md_if.HI !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h expected 00000000", md_if.HI); end
      n_cmp++; if (md_if.LO !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h expected 00000000", md_if.LO); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_mult();
      int n;
      bit st;
      issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
      wait_busy(n, st);
      n_cmp++; if (n != 5) begin n_err++; $display("FAIL mult_busy_len: got %0d expected 5", n); end
      n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL mult_hold: HI/LO changed during Busy, expected held"); end
      n_cmp++; if (md_if.HI !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi: got %h expected ffffffff", md_if.HI); end
      n_cmp++; if (md_if.LO !== 32'hFFFFFFFA) begin n_err++; $display("FAIL mult_lo: got %h expected fffffffa", md_if.LO); end
   endtask

   task automatic test_multu();
      int n;
      bit st;
      issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_busy(n, st);
      n_cmp++; if (n != 5) begin n_err++; $display("FAIL multu_busy_len: got %0d expected 5", n); end
      n_cmp++; if (md_if.HI !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_hi: got %h expected fffffffe", md_if.HI); end
      n_cmp++; if (md_if.LO !== 32'h00000001) begin n_err++; $display("FAIL multu_lo: got %h expected 00000001", md_if.LO); end
   endtask

   task automatic test_div();
      int n;
      bit st;
      issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
      wait_busy(n, st);
      n_cmp++; if (n != 10) begin n_err++; $display("FAIL div_busy_len: got %0d expected 10", n); end
      n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL div_hold: HI/LO changed during Busy, expected held"); end
      n_cmp++; if (md_if.LO !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo: got %h expected fffffffd", md_if.LO); end
      n_cmp++; if (md_if.HI !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi: got %h expected ffffffff", md_if.HI); end
   endtask

   task automatic test_div_zero();
      int n;
      bit st;
      issue(MD_DIVU, 32'd7, 32'd0);
      wait_busy(n, st);
      n_cmp++; if (n != 10) begin n_err++; $display("FAIL divz_busy_len: got %0d expected 10", n); end
      n_cmp++; if (md_if.HI !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divz_hi: got %h expected ffffffff", md_if.HI); end
      n_cmp++; if (md_if.LO !== 32'hFFFFFFFD) begin n_err++; $display("FAIL divz_lo: got %h expected fffffffd", md_if.LO); end
   endtask

   task automatic test_div_signs();
      int n;
      bit st;
      issue(MD_DIV, 32'd7, 32'hFFFFFFFE);
      wait_busy(n, st);
      n_cmp++; if (md_if.LO !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_negb_lo: got %h expected fffffffd", md_if.LO); end
      n_cmp++; if (md_if.HI !== 32'h00000001) begin n_err++; $display("FAIL div_negb_hi: got %h expected 00000001", md_if.HI); end
      issue(MD_DIVU, 32'd100, 32'd7);
      wait_busy(n, st);
      n_cmp++; if (md_if.LO !== 32'h0000000E) begin n_err++; $display("FAIL divu_lo: got %h expected 0000000e", md_if.LO); end
      n_cmp++; if (md_if.HI !== 32'h00000002) begin n_err++; $display("FAIL divu_hi: got %h expected 00000002", md_if.HI); end
      issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_busy(n, st);
      n_cmp++; if (md_if.LO !== 32'h80000000) begin n_err++; $display("FAIL div_ovf_lo: got %h expected 80000000", md_if.LO); end
      n_cmp++; if (md_if.HI !== 32'h00000000) begin n_err++; $display("FAIL div_ovf_hi: got %h expected 00000000", md_if.HI); end
   endtask

   task automatic test_mt();
      issue(MD_MTHI, 32'h12345678, 32'd0);
      n_cmp++; if (md_if.HI !== 32'h12345678) begin n_err++; $display("FAIL mthi_hi: got %h expected 12345678", md_if.HI); end
      n_cmp++; if (md_if.Busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy: got %b expected 0", md_if.Busy); end
      drive(MD_MTLO, 32'h0BADF00D, 32'd0, 1'b0, 1'b0);
      step();
      idle();
      n_cmp++; if (md_if.LO !== 32'h0BADF00D) begin n_err++; $display("FAIL mtlo_lo: got %h expected 0badf00d", md_if.LO); end
      n_cmp++; if (md_if.HI !== 32'h12345678) begin n_err++; $display("FAIL mtlo_hi_kept: got %h expected 12345678", md_if.HI); end
   endtask

   task automatic test_mt_during_run();
      int n;
      bit st;
      issue(MD_MULT, 32'd6, 32'd7);
      drive(MD_MTLO, 32'hDEADBEEF, 32'd0, 1'b1, 1'b0);
      step();
      drive(MD_MULT, 32'd100, 32'd100, 1'b1, 1'b0);
      step();
      drive(MD_MTHI, 32'hCAFECAFE, 32'd0, 1'b0, 1'b0);
      step();
      idle();
      wait_busy(n, st);
      n_cmp++; if (n + 3 != 5) begin n_err++; $display("FAIL run_ignore_len: got %0d expected 5", n + 3); end
      n_cmp++; if (md_if.LO !== 32'h0000002A) begin n_err++; $display("FAIL run_ignore_lo: got %h expected 0000002a", md_if.LO); end
      n_cmp++; if (md_if.HI !== 32'h00000000) begin n_err++; $display("FAIL run_ignore_hi: got %h expected 00000000", md_if.HI); end
   endtask

   task automatic test_cancel();
      int n;
      bit st;
      issue(MD_MTHI, 32'h11111111, 32'd0);
      issue(MD_MTLO, 32'h22222222, 32'd0);
      issue(MD_DIV, 32'd100, 32'd3);
      step();
      step();
      step();
      drive(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
      step();
      idle();
      n_cmp++; if (md_if.Busy !== 1'b0) begin n_err++; $display("FAIL cancel_busy: got %b expected 0", md_if.Busy); end
      n_cmp++; if (md_if.HI !== 32'h11111111) begin n_err++; $display("FAIL cancel_hi: got %h expected 11111111", md_if.HI); end
      n_cmp++; if (md_if.LO !== 32'h22222222) begin n_err++; $display("FAIL cancel_lo: got %h expected 22222222", md_if.LO); end
      issue(MD_MULT, 32'd9, 32'd9);
      n_cmp++; if (md_if.Busy !== 1'b1) begin n_err++; $display("FAIL post_cancel_start: got %b expected 1", md_if.Busy); end
      wait_busy(n, st);
      n_cmp++; if (n != 5) begin n_err++; $display("FAIL post_cancel_len: got %0d expected 5", n); end
      n_cmp++; if (md_if.LO !== 32'h00000051) begin n_err++; $display("FAIL post_cancel_lo: got %h expected 00000051", md_if.LO); end
      n_cmp++; if (md_if.HI !== 32'h00000000) begin n_err++; $display("FAIL post_cancel_hi: got %h expected 00000000", md_if.HI); end
      // Cancel in IDLE must swallow a same-cycle MTHI and Start.
      drive(MD_MTHI, 32'hABCDABCD, 32'd0, 1'b0, 1'b1);
      step();
      n_cmp++; if (md_if.HI !== 32'h00000000) begin n_err++; $display("FAIL idle_cancel_mthi: got %h expected 00000000", md_if.HI); end
      drive(MD_MULT, 32'd2, 32'd2, 1'b1, 1'b1);
      step();
      idle();
      n_cmp++; if (md_if.Busy !== 1'b0) begin n_err++; $display("FAIL idle_cancel_start: got %b expected 0", md_if.Busy); end
      // Cancel on the final RUN cycle beats the commit.
      issue(MD_MULT, 32'd3, 32'd5);
      step();
      step();
      step();
      step();
      drive(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
      step();
      idle();
      n_cmp++; if (md_if.Busy !== 1'b0) begin n_err++; $display("FAIL cancel_last_busy: got %b expected 0", md_if.Busy); end
      n_cmp++; if (md_if.LO !== 32'h00000051) begin n_err++; $display("FAIL cancel_last_lo: got %h expected 00000051", md_if.LO); end
   endtask

   task automatic test_reset_mid_run();
      issue(MD_MTHI, 32'h00000005, 32'd0);
      issue(MD_MTLO, 32'h00000006, 32'd0);
      issue(MD_MULT, 32'd7, 32'd7);
      step();
      step();
      reset = 1'b1;
      step();
      n_cmp++; if (md_if.Busy !== 1'b0) begin n_err++; $display("FAIL rst_run_busy: got %b expected 0", md_if.Busy); end
      n_cmp++; if (md_if.HI !== 32'd0) begin n_err++; $display("FAIL rst_run_hi: got %h expected 00000000", md_if.HI); end
      n_cmp++; if (md_if.LO !== 32'd0) begin n_err++; $display("FAIL rst_run_lo: got %h expected 00000000", md_if.LO); end
      reset = 1'b0;
      for (int i = 0; i < 6; i++) step();
      n_cmp++; if (md_if.LO !== 32'd0) begin n_err++; $display("FAIL rst_run_late_lo: got %h expected 00000000", md_if.LO); end
   endtask

   task automatic test_back_to_back();
      int n;
      bit st;
      issue(MD_MULT, 32'h00010000, 32'h00010000);
      wait_busy(n, st);
      n_cmp++; if (md_if.HI !== 32'h00000001 || md_if.LO !== 32'h00000000)
         begin n_err++; $display("FAIL b2b_first: got %h_%h expected 00000001_00000000", md_if.HI, md_if.LO); end
      issue(MD_MULT, 32'hFFFFFFFF, 32'd2);
      n_cmp++; if (md_if.Busy !== 1'b1) begin n_err++; $display("FAIL b2b_start: got %b expected 1", md_if.Busy); end
      wait_busy(n, st);
      n_cmp++; if (n != 5) begin n_err++; $display("FAIL b2b_len: got %0d expected 5", n); end
      n_cmp++; if (md_if.HI !== 32'hFFFFFFFF) begin n_err++; $display("FAIL b2b_hi: got %h expected ffffffff", md_if.HI); end
      n_cmp++; if (md_if.LO !== 32'hFFFFFFFE) begin n_err++; $display("FAIL b2b_lo: got %h expected fffffffe", md_if.LO); end
   endtask

   initial begin
      idle();
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_div_zero();
      test_div_signs();
      test_mt();
      test_mt_during_run();
      test_cancel();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule
